// File: rtl/tamaguchi_pkg.sv
// Shared Tamaguchi definitions: action IDs, arbiter FSM states and pending-bit layout.
// control_principal decodes the same action IDs.
package tamaguchi_pkg;

   localparam logic [2:0] ID_NONE   = 3'd0;
   localparam logic [2:0] ID_COMER  = 3'd1;
   localparam logic [2:0] ID_JUGAR  = 3'd2;
   localparam logic [2:0] ID_DORMIR = 3'd3;
   localparam logic [2:0] ID_TEST   = 3'd4;

   localparam int P_COMER  = 0;
   localparam int P_JUGAR  = 1;
   localparam int P_DORMIR = 2;
   localparam int P_TEST   = 3;

   localparam logic [1:0] RR_COMER  = 2'd0;
   localparam logic [1:0] RR_JUGAR  = 2'd1;
   localparam logic [1:0] RR_DORMIR = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_OFFER    = 2'd1,
      ST_COOLDOWN = 2'd2
   } estado_t;

   function automatic logic [3:0] id_a_mascara(input logic [2:0] id);
      case (id)
         ID_COMER:  id_a_mascara = 4'b0001;
         ID_JUGAR:  id_a_mascara = 4'b0010;
         ID_DORMIR: id_a_mascara = 4'b0100;
         ID_TEST:   id_a_mascara = 4'b1000;
         default:   id_a_mascara = 4'b0000;
      endcase
   endfunction

   // Round-robin resumes at the slot after the one just granted.
   function automatic logic [1:0] rr_siguiente(input logic [2:0] id);
      case (id)
         ID_COMER: rr_siguiente = RR_JUGAR;
         ID_JUGAR: rr_siguiente = RR_DORMIR;
         default:  rr_siguiente = RR_COMER;
      endcase
   endfunction

   function automatic logic [2:0] grant_a_id(input logic [2:0] g);
      if (g[0])      grant_a_id = ID_COMER;
      else if (g[1]) grant_a_id = ID_JUGAR;
      else if (g[2]) grant_a_id = ID_DORMIR;
      else           grant_a_id = ID_NONE;
   endfunction

endpackage

// File: rtl/rr_arbitro3.sv
// Combinational 3-way round-robin picker: first eligible slot at or after rr wins.
module rr_arbitro3
   import tamaguchi_pkg::*;
(
   input  logic [2:0] eligible,
   input  logic [1:0] rr,
   output logic [2:0] grant
);

   always_comb begin
      grant = 3'b000;
      case (rr)
         RR_JUGAR: begin
            if (eligible[1])      grant = 3'b010;
            else if (eligible[2]) grant = 3'b100;
            else if (eligible[0]) grant = 3'b001;
         end
         RR_DORMIR: begin
            if (eligible[2])      grant = 3'b100;
            else if (eligible[0]) grant = 3'b001;
            else if (eligible[1]) grant = 3'b010;
         end
         default: begin
            if (eligible[0])      grant = 3'b001;
            else if (eligible[1]) grant = 3'b010;
            else if (eligible[2]) grant = 3'b100;
         end
      endcase
   end

endmodule

// File: rtl/arbitro_acciones.sv
// Latches button edges and offers one action at a time to control_principal,
// with valid/ack handshake, ack timeout and a secondpassed-based cooldown.
module arbitro_acciones
   import tamaguchi_pkg::*;
#(
   parameter int COOLDOWN_S  = 2,
   parameter int ACK_TIMEOUT = 1023
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       secondpassed,
   input  logic       req_comer,
   input  logic       req_jugar,
   input  logic       req_dormir,
   input  logic       req_test,
   input  logic       dormido,
   input  logic       accion_ack,
   output logic       accion_valid,
   output logic [2:0] accion_id,
   output logic [3:0] pendientes,
   output logic       ocupado,
   output logic       err_timeout
);

   localparam int CW = (COOLDOWN_S > 0) ? $clog2(COOLDOWN_S + 1) : 1;

   estado_t     state, state_n;
   logic [3:0]  req_q, flancos, pend, pend_n, clr;
   logic [1:0]  rr, rr_n;
   logic [CW-1:0] cool, cool_n;
   logic [15:0] tcnt, tcnt_n;
   logic        valid_n, err_n;
   logic [2:0]  id_n, sel_id;
   logic [2:0]  elig3, grant;
   logic        hay_pend;

   assign flancos = {req_test, req_dormir, req_jugar, req_comer} & ~req_q;

   // Sleep masks comer/jugar from selection only; their bits stay latched.
   assign elig3 = {pend[P_DORMIR], pend[P_JUGAR] & ~dormido, pend[P_COMER] & ~dormido};

   rr_arbitro3 u_rr (
      .eligible (elig3),
      .rr       (rr),
      .grant    (grant)
   );

   assign sel_id   = pend[P_TEST] ? ID_TEST : grant_a_id(grant);
   assign hay_pend = pend[P_TEST] | (|elig3);

   always_comb begin
      state_n = state;
      clr     = 4'b0000;
      rr_n    = rr;
      cool_n  = cool;
      tcnt_n  = tcnt;
      valid_n = accion_valid;
      id_n    = accion_id;
      err_n   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (hay_pend) begin
               state_n = ST_OFFER;
               valid_n = 1'b1;
               id_n    = sel_id;
               tcnt_n  = '0;
            end
         end
         ST_OFFER: begin
            if (accion_ack) begin
               clr     = id_a_mascara(accion_id);
               if (accion_id != ID_TEST) rr_n = rr_siguiente(accion_id);
               valid_n = 1'b0;
               id_n    = ID_NONE;
               cool_n  = CW'(COOLDOWN_S);
               state_n = ST_COOLDOWN;
            end else if (tcnt == 16'(ACK_TIMEOUT - 1)) begin
               clr     = id_a_mascara(accion_id);
               err_n   = 1'b1;
               valid_n = 1'b0;
               id_n    = ID_NONE;
               state_n = ST_IDLE;
            end else begin
               tcnt_n = tcnt + 16'd1;
            end
         end
         ST_COOLDOWN: begin
            if (pend[P_TEST]) begin
               state_n = ST_OFFER;
               valid_n = 1'b1;
               id_n    = ID_TEST;
               tcnt_n  = '0;
            end else if (cool == '0) begin
               state_n = ST_IDLE;
            end else if (secondpassed) begin
               cool_n = cool - CW'(1);
            end
         end
         default: begin
            state_n = ST_IDLE;
            valid_n = 1'b0;
            id_n    = ID_NONE;
         end
      endcase
      // A fresh edge in the clearing cycle keeps its bit set.
      pend_n = (pend & ~clr) | flancos;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         req_q        <= '0;
         pend         <= '0;
         rr           <= RR_COMER;
         cool         <= '0;
         tcnt         <= '0;
         accion_valid <= 1'b0;
         accion_id    <= ID_NONE;
         err_timeout  <= 1'b0;
      end else begin
         state        <= state_n;
         req_q        <= {req_test, req_dormir, req_jugar, req_comer};
         pend         <= pend_n;
         rr           <= rr_n;
         cool         <= cool_n;
         tcnt         <= tcnt_n;
         accion_valid <= valid_n;
         accion_id    <= id_n;
         err_timeout  <= err_n;
      end
   end

   assign pendientes = pend;
   assign ocupado    = (state != ST_IDLE);

endmodule

// File: tb/tb_arbitro_acciones.sv
// Directed bench for arbitro_acciones with COOLDOWN_S=2 and ACK_TIMEOUT=8.
module tb_arbitro_acciones;

   logic       clk = 1'b0;
   logic       rst, secondpassed, dormido, accion_ack;
   logic       req_comer, req_jugar, req_dormir, req_test;
   logic       accion_valid, ocupado, err_timeout;
   logic [2:0] accion_id;
   logic [3:0] pendientes;

   int n_chk = 0;
   int n_err = 0;

   arbitro_acciones #(.COOLDOWN_S(2), .ACK_TIMEOUT(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .secondpassed (secondpassed),
      .req_comer    (req_comer),
      .req_jugar    (req_jugar),
      .req_dormir   (req_dormir),
      .req_test     (req_test),
      .dormido      (dormido),
      .accion_ack   (accion_ack),
      .accion_valid (accion_valid),
      .accion_id    (accion_id),
      .pendientes   (pendientes),
      .ocupado      (ocupado),
      .err_timeout  (err_timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clr_inputs();
      secondpassed = 0; dormido = 0; accion_ack = 0;
      req_comer = 0; req_jugar = 0; req_dormir = 0; req_test = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      clr_inputs();
      tick();
      tick();
      rst = 0;
   endtask

   // Wait (bounded) for an offer, check its id, ack it and check the drop.
   task automatic serve(input string tag, input int exp_id);
      int n = 0;
      while (!accion_valid && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, 32'(accion_valid), 1);
      chk({tag, "_id"}, 32'(accion_id), 32'(exp_id));
      accion_ack = 1;
      tick();
      accion_ack = 0;
      chk({tag, "_drop"}, 32'(accion_valid), 0);
   endtask

   initial begin
      // 1: reset values, single comer press, ack 3 cycles after valid, cooldown
      do_reset();
      chk("rst_valid", 32'(accion_valid), 0);
      chk("rst_id", 32'(accion_id), 0);
      chk("rst_pend", 32'(pendientes), 0);
      chk("rst_ocup", 32'(ocupado), 0);
      chk("rst_err", 32'(err_timeout), 0);
      req_comer = 1;
      tick();
      chk("t1_pend", 32'(pendientes), 1);
      chk("t1_novalid", 32'(accion_valid), 0);
      tick();
      chk("t1_valid", 32'(accion_valid), 1);
      chk("t1_id", 32'(accion_id), 1);
      chk("t1_ocup", 32'(ocupado), 1);
      tick();
      tick();
      chk("t1_hold_id", 32'(accion_id), 1);
      accion_ack = 1;
      tick();
      accion_ack = 0;
      chk("t1_ackdrop", 32'(accion_valid), 0);
      chk("t1_ackid", 32'(accion_id), 0);
      chk("t1_clr", 32'(pendientes), 0);
      chk("t1_cool_ocup", 32'(ocupado), 1);
      secondpassed = 1; tick(); secondpassed = 0;
      tick(); tick();
      chk("t1_cool1", 32'(ocupado), 1);
      secondpassed = 1; tick(); secondpassed = 0;
      chk("t1_cool2", 32'(ocupado), 1);
      tick();
      chk("t1_idle", 32'(ocupado), 0);
      tick(); tick();
      chk("t1_held_noreq", 32'(accion_valid), 0);
      chk("t1_held_pend", 32'(pendientes), 0);

      // 2: simultaneous presses, round-robin order
      do_reset();
      secondpassed = 1;
      req_comer = 1; req_jugar = 1; req_dormir = 1;
      serve("t2_a", 1);
      chk("t2_pend", 32'(pendientes), 6);
      serve("t2_b", 2);
      serve("t2_c", 3);
      req_comer = 0; req_jugar = 0; req_dormir = 0;
      tick();
      req_comer = 1;
      serve("t2_r2", 1);
      req_comer = 0;
      tick();
      req_comer = 1; req_dormir = 1;
      serve("t2_rr_d", 3);
      serve("t2_rr_c", 1);

      // 3: dormido masks comer
      do_reset();
      secondpassed = 1;
      dormido = 1;
      req_comer = 1; req_dormir = 1;
      serve("t3_dorm", 3);
      repeat (6) tick();
      chk("t3_masked", 32'(accion_valid), 0);
      chk("t3_latched", 32'(pendientes), 1);
      dormido = 0;
      serve("t3_comer", 1);

      // 4: test aborts cooldown, does not move rr
      do_reset();
      req_jugar = 1;
      serve("t4_jugar", 2);
      chk("t4_incool", 32'(ocupado), 1);
      req_test = 1;
      tick();
      chk("t4_novalid", 32'(accion_valid), 0);
      chk("t4_pend", 32'(pendientes), 8);
      tick();
      chk("t4_valid", 32'(accion_valid), 1);
      chk("t4_id", 32'(accion_id), 4);
      accion_ack = 1;
      tick();
      accion_ack = 0;
      chk("t4_drop", 32'(accion_valid), 0);
      chk("t4_clr", 32'(pendientes), 0);
      chk("t4_cool", 32'(ocupado), 1);
      req_jugar = 0; req_test = 0;
      secondpassed = 1;
      tick();
      req_comer = 1; req_jugar = 1; req_dormir = 1;
      serve("t4_rr_d", 3);
      serve("t4_rr_c", 1);

      // 5: ack timeout
      do_reset();
      req_dormir = 1;
      tick();
      tick();
      chk("t5_valid", 32'(accion_valid), 1);
      chk("t5_id", 32'(accion_id), 3);
      repeat (7) tick();
      chk("t5_still", 32'(accion_valid), 1);
      chk("t5_noerr", 32'(err_timeout), 0);
      tick();
      chk("t5_drop", 32'(accion_valid), 0);
      chk("t5_err", 32'(err_timeout), 1);
      chk("t5_id0", 32'(accion_id), 0);
      chk("t5_clr", 32'(pendientes), 0);
      chk("t5_idle", 32'(ocupado), 0);
      tick();
      chk("t5_errpulse", 32'(err_timeout), 0);
      chk("t5_noreoffer", 32'(accion_valid), 0);

      // 6: reset while offering
      do_reset();
      req_jugar = 1;
      tick();
      tick();
      chk("t6_valid", 32'(accion_valid), 1);
      chk("t6_id", 32'(accion_id), 2);
      rst = 1;
      req_jugar = 0;
      tick();
      chk("t6_rvalid", 32'(accion_valid), 0);
      chk("t6_rid", 32'(accion_id), 0);
      chk("t6_rpend", 32'(pendientes), 0);
      chk("t6_rocup", 32'(ocupado), 0);
      chk("t6_rerr", 32'(err_timeout), 0);
      rst = 0;
      tick();
      req_comer = 1;
      tick();
      tick();
      chk("t6_after_valid", 32'(accion_valid), 1);
      chk("t6_after_id", 32'(accion_id), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/arbitro_acciones.md
# arbitro_acciones

Sequences user and test requests into the main Tamaguchi control FSM, one action at a time. It sits between the debounced button outputs and `control_principal`. It latches button presses, picks one pending action (test by fixed priority, comer/jugar/dormir round-robin), offers it with a valid/ack handshake, and then enforces a cooldown measured in `secondpassed` ticks. This prevents a held or rapidly repeated button from flooding the pet state machine.

## Interface
- `COOLDOWN_S`, 2: seconds (`secondpassed` pulses) of lockout after an acknowledged action; 0 allowed.
- `ACK_TIMEOUT`, 1023: clock cycles an offer waits for `accion_ack` before it is dropped; range 1..65535.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset, synchronous, active-high.
- `secondpassed`  in  1  one-cycle pulse per (possibly accelerated) second.
- `req_comer`, `req_jugar`, `req_dormir`, `req_test`  in  1 each  debounced button levels, active-high.
- `dormido`  in  1  pet asleep; masks comer/jugar eligibility.
- `accion_ack`  in  1  main FSM accepted the offered action.
- `accion_valid`  out  1  action offered.
- `accion_id`  out  3  0 none, 1 comer, 2 jugar, 3 dormir, 4 test.
- `pendientes`  out  4  latched requests {test, dormir, jugar, comer}.
- `ocupado`  out  1  high in OFFER or COOLDOWN.
- `err_timeout`  out  1  one-cycle pulse when an offer times out.

## Operation
- Edge detect: each `req_*` is registered. A rising edge (`req & ~req_q`) sets that request's pending bit at the same clock edge. Pending bits are 1-bit, so duplicate presses coalesce. A held level generates no further requests.
- Eligibility:
  - test and dormir are always eligible.
  - comer and jugar are eligible only while `dormido`=0.
  - Masked requests stay latched.
- Selection: if test is pending and eligible, it wins. Otherwise a round-robin over comer→jugar→dormir starts at pointer `rr`.
- FSM states:
  - IDLE → OFFER when any eligible pending bit exists. `accion_id` and `accion_valid` are registered on entry.
  - OFFER holds `accion_id` stable while `accion_valid`=1.
    - `accion_ack`=1 sampled: clear that pending bit, set `rr` to the slot after the granted one (test does not move `rr`), drop valid, load cooldown counter with `COOLDOWN_S`, go to COOLDOWN.
    - Timeout counter reaches `ACK_TIMEOUT`: clear that pending bit, pulse `err_timeout`, drop valid, go to IDLE with no cooldown.
  - COOLDOWN decrements on each `secondpassed`. At 0 it goes to IDLE. With `COOLDOWN_S`=0 it exits on the next cycle.
    - A pending test aborts the cooldown and goes directly to OFFER(test).
- Simultaneous events:
  - Set wins over clear: a new edge on the acknowledged request in the ack cycle leaves its pending bit at 1.
  - Ack and timeout in the same cycle: ack wins.
  - `accion_ack` outside OFFER is ignored.
- Reset mid-operation: every state returns to IDLE and everything clears. Pending requests are lost and `rr` goes to comer.

## Timing
- Reset values:
  - `accion_valid`=0, `accion_id`=0, `pendientes`=0, `ocupado`=0, `err_timeout`=0.
  - FSM=IDLE, `rr`=comer, edge registers=0.
- Press-to-offer latency is 2 cycles: a rising edge sampled at edge k sets pending after k, and valid is high after k+1.
- Ack-to-release: valid is low the cycle after ack is sampled, and `ocupado` stays high through the cooldown.
- Timeout: valid drops after exactly `ACK_TIMEOUT` cycles in OFFER with no ack.
- `accion_id` changes only on entry to OFFER. It reads 0 whenever valid is 0.

## Structure
- Shared package `tamaguchi_pkg` holds:
  - the action ID constants (NONE, COMER, JUGAR, DORMIR, TEST);
  - the FSM state encoding;
  - the `pendientes` bit indices.
  `control_principal` uses the same IDs.
- One sub-module, `rr_arbitro3`: a 3-request round-robin picker (`eligible[2:0]`, `rr` in → one-hot grant), purely combinational.
- Cooldown counter width is `$clog2(COOLDOWN_S+1)`, minimum 1. Timeout counter is 16 bits.

## Test plan
- Reset, single comer press, ack 3 cycles after valid → `accion_id`=1 two cycles after the edge; pending clears; `ocupado` stays high for 2 `secondpassed` pulses.
- comer, jugar and dormir pressed in the same cycle, each acked immediately with `secondpassed` forced every cycle → grant order is 1, 2, 3; a second round starts at comer.
- `dormido`=1 with comer and dormir pending → dormir (3) is granted; comer stays latched and is granted after `dormido` falls.
- During COOLDOWN with 2 s remaining, press test → valid with id 4 next-but-one cycle, and cooldown is aborted.
- No ack with `ACK_TIMEOUT`=8 → valid drops after 8 cycles; `err_timeout` pulses once; FSM returns to IDLE with the pending bit cleared.
- Assert `rst` while in OFFER with jugar pending → next cycle all outputs are 0 and a subsequent press is handled normally.
